// File: rtl/pe_feeder.sv
`default_nettype none
// ============================================================================
// pe_feeder : loads a kernel into one PE, streams activations, returns result
// Rev 1.0
// ============================================================================
module pe_feeder #(
  parameter int DATA_WID = 8,
  parameter int ICP_NUM  = 4,
  parameter int ADDR_B   = 4,
  parameter int OUT_WID  = 16,
  parameter int TIMEOUT  = 64
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        start,
  input  logic [ADDR_B-1:0]           klen,
  input  logic                        w_valid,
  input  logic [DATA_WID-1:0]         w_data,
  input  logic [ICP_NUM-1:0]          w_mask,
  output logic                        w_ready,
  input  logic                        a_valid,
  input  logic [ICP_NUM*DATA_WID-1:0] a_data,
  output logic                        a_ready,
  output logic [1:0]                  pe_state,
  output logic [ICP_NUM*DATA_WID-1:0] pe_a,
  output logic [DATA_WID-1:0]         pe_wrb_data,
  output logic [ADDR_B-1:0]           pe_wrb_addr,
  output logic [ICP_NUM-1:0]          pe_wrb,
  output logic [ADDR_B-1:0]           pe_rdb_addr,
  input  logic [1:0]                  pe_out_state,
  input  logic [OUT_WID-1:0]          pe_out_data,
  output logic                        r_valid,
  output logic [OUT_WID-1:0]          r_data,
  input  logic                        r_ready,
  output logic                        busy,
  output logic                        err
);

  localparam logic [1:0] PE_INVALID = 2'd0;
  localparam logic [1:0] PE_VALID   = 2'd1;
  localparam logic [1:0] PE_CNN_FIN = 2'd2;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LOAD_W = 3'd1;
  localparam logic [2:0] S_STREAM = 3'd2;
  localparam logic [2:0] S_WAIT   = 3'd3;
  localparam logic [2:0] S_OUT    = 3'd4;

  localparam int               CNT_W    = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  logic [2:0]                  state_q, state_d;
  logic [ADDR_B-1:0]           klen_q, klen_d;
  logic [ADDR_B-1:0]           idx_q, idx_d;
  logic [CNT_W-1:0]            wcnt_q, wcnt_d;
  logic [1:0]                  pe_state_q, pe_state_d;
  logic [ICP_NUM*DATA_WID-1:0] pe_a_q, pe_a_d;
  logic [DATA_WID-1:0]         pe_wrb_data_q, pe_wrb_data_d;
  logic [ADDR_B-1:0]           pe_wrb_addr_q, pe_wrb_addr_d;
  logic [ICP_NUM-1:0]          pe_wrb_q, pe_wrb_d;
  logic [ADDR_B-1:0]           pe_rdb_addr_q, pe_rdb_addr_d;
  logic                        r_valid_q, r_valid_d;
  logic [OUT_WID-1:0]          r_data_q, r_data_d;
  logic                        err_q, err_d;

  always_comb begin
    state_d       = state_q;
    klen_d        = klen_q;
    idx_d         = idx_q;
    wcnt_d        = wcnt_q;
    pe_state_d    = PE_INVALID;
    pe_wrb_d      = '0;
    pe_a_d        = pe_a_q;
    pe_wrb_data_d = pe_wrb_data_q;
    pe_wrb_addr_d = pe_wrb_addr_q;
    pe_rdb_addr_d = pe_rdb_addr_q;
    r_valid_d     = r_valid_q;
    r_data_d      = r_data_q;
    err_d         = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          klen_d  = klen;
          idx_d   = '0;
          state_d = S_LOAD_W;
        end
      end
      S_LOAD_W: begin
        if (w_valid) begin
          pe_wrb_data_d = w_data;
          pe_wrb_addr_d = idx_q;
          pe_wrb_d      = w_mask;
          if (idx_q == klen_q) begin
            idx_d   = '0;
            state_d = S_STREAM;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      S_STREAM: begin
        if (a_valid) begin
          pe_a_d        = a_data;
          pe_rdb_addr_d = idx_q;
          // The final beat carries CNN_FIN instead of VALID.
          if (idx_q == klen_q) begin
            pe_state_d = PE_CNN_FIN;
            wcnt_d     = '0;
            idx_d      = '0;
            state_d    = S_WAIT;
          end else begin
            pe_state_d = PE_VALID;
            idx_d      = idx_q + 1'b1;
          end
        end
      end
      S_WAIT: begin
        // A result arriving on the timeout cycle still takes priority.
        if (pe_out_state == PE_CNN_FIN) begin
          r_data_d  = pe_out_data;
          r_valid_d = 1'b1;
          state_d   = S_OUT;
        end else if (wcnt_q == CNT_LAST) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          wcnt_d = wcnt_q + 1'b1;
        end
      end
      S_OUT: begin
        if (r_ready) begin
          r_valid_d = 1'b0;
          state_d   = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_IDLE;
      klen_q        <= '0;
      idx_q         <= '0;
      wcnt_q        <= '0;
      pe_state_q    <= PE_INVALID;
      pe_a_q        <= '0;
      pe_wrb_data_q <= '0;
      pe_wrb_addr_q <= '0;
      pe_wrb_q      <= '0;
      pe_rdb_addr_q <= '0;
      r_valid_q     <= 1'b0;
      r_data_q      <= '0;
      err_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      klen_q        <= klen_d;
      idx_q         <= idx_d;
      wcnt_q        <= wcnt_d;
      pe_state_q    <= pe_state_d;
      pe_a_q        <= pe_a_d;
      pe_wrb_data_q <= pe_wrb_data_d;
      pe_wrb_addr_q <= pe_wrb_addr_d;
      pe_wrb_q      <= pe_wrb_d;
      pe_rdb_addr_q <= pe_rdb_addr_d;
      r_valid_q     <= r_valid_d;
      r_data_q      <= r_data_d;
      err_q         <= err_d;
    end
  end

  assign w_ready     = (state_q == S_LOAD_W);
  assign a_ready     = (state_q == S_STREAM);
  assign busy        = (state_q != S_IDLE);
  assign pe_state    = pe_state_q;
  assign pe_a        = pe_a_q;
  assign pe_wrb_data = pe_wrb_data_q;
  assign pe_wrb_addr = pe_wrb_addr_q;
  assign pe_wrb      = pe_wrb_q;
  assign pe_rdb_addr = pe_rdb_addr_q;
  assign r_valid     = r_valid_q;
  assign r_data      = r_data_q;
  assign err         = err_q;

endmodule
`default_nettype wire

// File: tb/tb_pe_feeder.sv
`default_nettype none
// ============================================================================
// tb_pe_feeder : scoreboard bench for pe_feeder
// Rev 1.0
// ============================================================================
module tb_pe_feeder;

  logic        clk = 1'b0;
  logic        reset, start;
  logic [3:0]  klen;
  logic        w_valid;
  logic [7:0]  w_data;
  logic [3:0]  w_mask;
  logic        w_ready;
  logic        a_valid;
  logic [31:0] a_data;
  logic        a_ready;
  logic [1:0]  pe_state;
  logic [31:0] pe_a;
  logic [7:0]  pe_wrb_data;
  logic [3:0]  pe_wrb_addr;
  logic [3:0]  pe_wrb;
  logic [3:0]  pe_rdb_addr;
  logic [1:0]  pe_out_state;
  logic [15:0] pe_out_data;
  logic        r_valid;
  logic [15:0] r_data;
  logic        r_ready;
  logic        busy;
  logic        err;

  pe_feeder dut (
    .clk(clk), .reset(reset), .start(start), .klen(klen),
    .w_valid(w_valid), .w_data(w_data), .w_mask(w_mask), .w_ready(w_ready),
    .a_valid(a_valid), .a_data(a_data), .a_ready(a_ready),
    .pe_state(pe_state), .pe_a(pe_a), .pe_wrb_data(pe_wrb_data),
    .pe_wrb_addr(pe_wrb_addr), .pe_wrb(pe_wrb), .pe_rdb_addr(pe_rdb_addr),
    .pe_out_state(pe_out_state), .pe_out_data(pe_out_data),
    .r_valid(r_valid), .r_data(r_data), .r_ready(r_ready),
    .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    logic [63:0] val;
  } exp_t;

  exp_t wq[$];
  exp_t aq[$];
  exp_t mon_e;
  int   n_vec = 0;
  int   n_err = 0;
  int   last_cyc = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Every strobe / non-INVALID beat must match the next expected entry, in the right cycle.
  always @(negedge clk) begin
    if (pe_wrb != 4'd0) begin
      if (wq.size() == 0) begin
        check("wrb_unexpected", 64'(pe_wrb), 64'd0);
      end else begin
        mon_e = wq.pop_front();
        check("wrb_cycle", 64'(cyc), 64'(mon_e.cyc));
        check("wrb_beat", 64'({pe_wrb_addr, pe_wrb_data, pe_wrb}), mon_e.val);
      end
    end
    if (pe_state != 2'd0) begin
      if (aq.size() == 0) begin
        check("act_unexpected", 64'(pe_state), 64'd0);
      end else begin
        mon_e = aq.pop_front();
        check("act_cycle", 64'(cyc), 64'(mon_e.cyc));
        check("act_beat", 64'({pe_state, pe_rdb_addr, pe_a}), mon_e.val);
      end
    end
  end

  task automatic do_start(input logic [3:0] k);
    start = 1'b1;
    klen  = k;
    @(negedge clk);
    start = 1'b0;
    check("busy_after_start", 64'(busy), 64'd1);
  endtask

  task automatic drive_w(input logic [7:0] d, input logic [3:0] m, input logic [3:0] addr);
    exp_t e;
    int   t = 0;
    w_valid = 1'b1;
    w_data  = d;
    w_mask  = m;
    while (!w_ready && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (!w_ready) begin
      check("w_ready_timeout", 64'(w_ready), 64'd1);
    end else begin
      e.cyc = cyc + 1;
      e.val = 64'({addr, d, m});
      wq.push_back(e);
    end
    @(negedge clk);
  endtask

  task automatic drive_a(input int b, input int k);
    exp_t        e;
    logic [31:0] ad;
    logic [1:0]  st;
    int          t = 0;
    for (int i = 0; i < 4; i++) ad[i*8 +: 8] = 8'(16 * i + b);
    st      = (b == k) ? 2'd2 : 2'd1;
    a_valid = 1'b1;
    a_data  = ad;
    while (!a_ready && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (!a_ready) begin
      check("a_ready_timeout", 64'(a_ready), 64'd1);
    end else begin
      e.cyc = cyc + 1;
      e.val = 64'({st, 4'(b), ad});
      aq.push_back(e);
      last_cyc = cyc + 1;
    end
    @(negedge clk);
  endtask

  task automatic load(input int k, input logic [3:0] m, input bit glitch);
    for (int i = 0; i <= k; i++) begin
      if (glitch && i == 4) begin
        start = 1'b1;
        klen  = 4'd2;
      end
      drive_w(8'(i + 1), m, 4'(i));
      start = 1'b0;
    end
    w_valid = 1'b0;
  endtask

  task automatic stream(input int k, input int bubble);
    for (int b = 0; b <= k; b++) begin
      if (b == bubble) begin
        a_valid = 1'b0;
        @(negedge clk);
        check("bubble_state", 64'(pe_state), 64'd0);
        check("bubble_addr", 64'(pe_rdb_addr), 64'(b - 1));
      end
      drive_a(b, k);
    end
    a_valid = 1'b0;
  endtask

  // PE stub: result five cycles after the CNN_FIN beat, consumer stalls three cycles.
  task automatic respond(input logic [15:0] d);
    check("rvalid_before", 64'(r_valid), 64'd0);
    repeat (5) @(negedge clk);
    pe_out_state = 2'd2;
    pe_out_data  = d;
    @(negedge clk);
    pe_out_state = 2'd0;
    pe_out_data  = 16'h0;
    for (int i = 0; i < 3; i++) begin
      check("rvalid_hold", 64'(r_valid), 64'd1);
      check("rdata_hold", 64'(r_data), 64'(d));
      @(negedge clk);
    end
    r_ready = 1'b1;
    check("busy_at_ready", 64'(busy), 64'd1);
    @(negedge clk);
    r_ready = 1'b0;
    check("rvalid_after", 64'(r_valid), 64'd0);
    check("busy_after", 64'(busy), 64'd0);
  endtask

  task automatic check_reset_vals();
    check("rst_pe_state", 64'(pe_state), 64'd0);
    check("rst_pe_wrb", 64'(pe_wrb), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_r_valid", 64'(r_valid), 64'd0);
    check("rst_pe_bus", 64'({pe_a, pe_wrb_data, pe_wrb_addr, pe_rdb_addr}), 64'd0);
    check("rst_misc", 64'({w_ready, a_ready, err, r_data}), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int errs;
    int errc;
    int ent;
    reset = 1'b1; start = 1'b0; klen = 4'd0;
    w_valid = 1'b0; w_data = 8'd0; w_mask = 4'd0;
    a_valid = 1'b0; a_data = 32'd0;
    pe_out_state = 2'd0; pe_out_data = 16'd0; r_ready = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_vals();
    reset = 1'b0;
    @(negedge clk);
    check_reset_vals();

    // klen=8 with an ignored start pulse mid-load
    do_start(4'd8);
    load(8, 4'hF, 1'b1);
    stream(8, -1);
    respond(16'h1234);

    // back-to-back start, bubble before beat 4
    do_start(4'd8);
    load(8, 4'hF, 1'b0);
    stream(8, 4);
    respond(16'h4321);

    // klen=0, PE never answers
    do_start(4'd0);
    load(0, 4'b0101, 1'b0);
    stream(0, -1);
    ent  = last_cyc;
    errs = 0;
    errc = -1;
    for (int t = 0; t < 100; t++) begin
      @(negedge clk);
      if (err) begin
        errs++;
        errc = cyc;
        check("err_busy", 64'(busy), 64'd0);
        check("err_rvalid", 64'(r_valid), 64'd0);
      end
    end
    check("err_count", 64'(errs), 64'd1);
    check("err_cycle", 64'(errc), 64'(ent + 64));

    // full address range; stray CNN_FIN outside WAIT must be ignored
    pe_out_state = 2'd2;
    pe_out_data  = 16'hDEAD;
    do_start(4'd15);
    load(15, 4'b1010, 1'b0);
    pe_out_state = 2'd0;
    pe_out_data  = 16'h0;
    stream(15, -1);
    respond(16'hBEEF);

    // reset in the middle of streaming
    do_start(4'd8);
    load(8, 4'hF, 1'b0);
    for (int b = 0; b < 3; b++) drive_a(b, 8);
    reset   = 1'b1;
    a_valid = 1'b1;
    @(negedge clk);
    check_reset_vals();
    reset   = 1'b0;
    a_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_wq_empty", 64'(wq.size()), 64'd0);
    check("rst_aq_empty", 64'(aq.size()), 64'd0);
    do_start(4'd8);
    load(8, 4'hF, 1'b0);
    stream(8, -1);
    respond(16'h5555);

    repeat (3) @(negedge clk);
    check("end_wq_empty", 64'(wq.size()), 64'd0);
    check("end_aq_empty", 64'(aq.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
